// File: rtl/counter_scheduler_if.sv
// Requester / shared-counter bundle for counter_scheduler.
// The slave side belongs to the scheduler. The master side belongs to the environment,
// meaning the requesters plus the shared up_counter.
interface counter_scheduler_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] tgt;
  logic [W-1:0]   count;
  logic           cnt_rst;
  logic           cnt_en;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;

  modport master (
    output req, tgt, count,
    input  cnt_rst, cnt_en, grant, done, busy
  );

  modport slave (
    input  req, tgt, count,
    output cnt_rst, cnt_en, grant, done, busy
  );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin scheduler that time-shares one up_counter among N requesters.
// A granted requester's target is latched when it is granted. The counter is cleared and
// then run until it matches that target, and a one-cycle done pulse goes to the owner.
module counter_scheduler #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic              clk,
  input logic              rst,
  counter_scheduler_if.slave bus
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] own_q, own_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [W-1:0]    tgt_q, tgt_d;

  logic [IdxW-1:0] win_idx;
  logic            win_vld;
  int unsigned     cand;
  logic [N-1:0]    own_oh;

  // Round-robin pick: scan last+1, last+2, ... mod N; first asserted req wins
  always_comb begin
    win_idx = last_q;
    win_vld = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last_q) + off) % N;
      if (!win_vld && bus.req[IdxW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IdxW'(cand);
      end
    end
  end

  // Next-state logic, plus capture of the owner, the pointer and the target on grant
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StRun;
          own_d   = win_idx;
          last_d  = win_idx;
          tgt_d   = bus.tgt[win_idx*W +: W];
        end
      end
      StRun: begin
        // Abort wins over a simultaneous match
        if (!bus.req[own_q]) begin
          state_d = StIdle;
        end else if (bus.count == tgt_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      own_q   <= '0;
      last_q  <= IdxW'(N - 1);
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      tgt_q   <= tgt_d;
    end
  end

  // One-hot decode of the registered owner
  always_comb begin
    own_oh = {{(N-1){1'b0}}, 1'b1} << own_q;
  end

  // Moore outputs; IDLE and DONE hold the counter in clear so every run starts at 0
  always_comb begin
    bus.cnt_rst = 1'b1;
    bus.cnt_en  = 1'b0;
    bus.grant   = '0;
    bus.done    = '0;
    bus.busy    = 1'b0;
    unique case (state_q)
      StRun: begin
        bus.cnt_rst = 1'b0;
        bus.cnt_en  = 1'b1;
        bus.grant   = own_oh;
        bus.busy    = 1'b1;
      end
      StDone: begin
        bus.grant = own_oh;
        bus.done  = own_oh;
        bus.busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
